// File: rtl/store_write_buffer.sv
// M-stage store buffer: formats sw/sh/sb into word-aligned lane data
// and drains them in order to data memory over a req/ack handshake.
module store_write_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_type,
  output logic             st_ready,
  output logic             st_misalign,
  input  logic             ld_check,
  input  logic [31:0]      ld_addr,
  output logic             ld_hazard,
  output logic             dm_req,
  output logic [31:0]      dm_addr,
  output logic [31:0]      dm_wdata,
  output logic [3:0]       dm_be,
  input  logic             dm_ack,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DEPTH-1:0] vld_q;
  logic [29:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       be_q   [DEPTH];

  logic        full;
  logic        push;
  logic        pop;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_data;
  logic        haz;

  logic unused_ld_lo;
  assign unused_ld_lo = ^ld_addr[1:0];

  always_comb begin
    fmt_be   = 4'b0000;
    fmt_data = st_data;
    unique case (st_type)
      2'b00: fmt_be = 4'b1111;
      2'b01: begin
        fmt_be   = st_addr[1] ? 4'b1100 : 4'b0011;
        fmt_data = {2{st_data[15:0]}};
      end
      2'b10: begin
        fmt_be   = 4'b0001 << st_addr[1:0];
        fmt_data = {4{st_data[7:0]}};
      end
      default: fmt_be = 4'b0000;
    endcase
  end

  assign st_misalign = st_valid &
                       (((st_type == 2'b01) & st_addr[0]) |
                        ((st_type == 2'b00) & (st_addr[1:0] != 2'b00)));

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign st_ready = ~full;
  assign push     = st_valid & st_ready & ~st_misalign & (st_type != 2'b11);
  assign dm_req   = (cnt_q != '0);
  assign pop      = dm_req & dm_ack;
  assign count    = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        be_q[i]   <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail_q] <= st_addr[31:2];
        data_q[tail_q] <= fmt_data;
        be_q[tail_q]   <= fmt_be;
        vld_q[tail_q]  <= 1'b1;
        tail_q         <= tail_q + 1'b1;
      end
      // push and pop never target the same slot: that needs empty or full
      if (pop) begin
        vld_q[head_q] <= 1'b0;
        head_q        <= head_q + 1'b1;
      end
      if (push & ~pop)
        cnt_q <= cnt_q + CNT_W'(1);
      else if (pop & ~push)
        cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign dm_addr  = dm_req ? {addr_q[head_q], 2'b00} : '0;
  assign dm_wdata = dm_req ? data_q[head_q] : '0;
  assign dm_be    = dm_req ? be_q[head_q] : '0;

  // an entry being acked this cycle is still valid, so it still counts
  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && (addr_q[i] == ld_addr[31:2]))
        haz = 1'b1;
  end

  assign ld_hazard = ld_check & haz;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed plan steps plus random traffic
// against a queue-based reference of the store buffer behaviour.
module tb_store_write_buffer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             st_valid;
  logic [31:0]      st_addr;
  logic [31:0]      st_data;
  logic [1:0]       st_type;
  logic             st_ready;
  logic             st_misalign;
  logic             ld_check;
  logic [31:0]      ld_addr;
  logic             ld_hazard;
  logic             dm_req;
  logic [31:0]      dm_addr;
  logic [31:0]      dm_wdata;
  logic [3:0]       dm_be;
  logic             dm_ack;
  logic [CNT_W-1:0] count;

  store_write_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_type(st_type), .st_ready(st_ready), .st_misalign(st_misalign),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hazard(ld_hazard),
    .dm_req(dm_req), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_be(dm_be), .dm_ack(dm_ack), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  int tests = 0;
  int fails = 0;
  int accepted = 0;
  int retired = 0;
  logic last_push;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t fmt(input logic [31:0] a, input logic [31:0] d,
                               input logic [1:0] t);
    ent_t e;
    e.addr = a & 32'hFFFF_FFFC;
    e.data = d;
    e.be   = 4'hF;
    if (t == 2'd1) begin
      e.data = {16'h0, d[15:0]} * 32'h0001_0001;
      e.be   = a[1] ? 4'b1100 : 4'b0011;
    end else if (t == 2'd2) begin
      e.data = {24'h0, d[7:0]} * 32'h0101_0101;
      e.be   = 4'(1 << a[1:0]);
    end
    return e;
  endfunction

  // One clock: drive, check every output against the model, then advance.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] t, input logic lc,
                     input logic [31:0] la, input logic ack);
    logic e_mis, e_rdy, e_push, e_pop, e_haz;
    ent_t e;
    st_valid = v; st_addr = a; st_data = d; st_type = t;
    ld_check = lc; ld_addr = la; dm_ack = ack;
    #1;
    e_mis  = v && ((t == 2'd1 && a[0]) || (t == 2'd0 && a[1:0] != 2'd0));
    e_rdy  = q.size() < DEPTH;
    e_push = v && e_rdy && !e_mis && t != 2'd3;
    e_pop  = q.size() != 0 && ack;
    e_haz  = 1'b0;
    foreach (q[i]) if (q[i].addr[31:2] == la[31:2]) e_haz = 1'b1;
    e_haz  = e_haz && lc;
    chk("st_ready", st_ready, e_rdy);
    chk("st_misalign", st_misalign, e_mis);
    chk("ld_hazard", ld_hazard, e_haz);
    chk("count", count, q.size());
    chk("dm_req", dm_req, q.size() != 0);
    chk("dm_addr", dm_addr, q.size() != 0 ? q[0].addr : 32'h0);
    chk("dm_wdata", dm_wdata, q.size() != 0 ? q[0].data : 32'h0);
    chk("dm_be", dm_be, q.size() != 0 ? q[0].be : 4'h0);
    e = fmt(a, d, t);
    last_push = e_push;
    @(posedge clk);
    if (e_pop) begin void'(q.pop_front()); retired++; end
    if (e_push) begin q.push_back(e); accepted++; end
    #1;
  endtask

  task automatic idle(input logic ack);
    cyc(1'b0, 32'h0, 32'h0, 2'd3, 1'b0, 32'h0, ack);
  endtask

  initial begin
    reset = 1'b1;
    st_valid = 0; st_addr = 0; st_data = 0; st_type = 2'd3;
    ld_check = 0; ld_addr = 0; dm_ack = 0;
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // reset state
    chk("rst_count", count, 0);
    chk("rst_ready", st_ready, 1);
    idle(1'b0);

    // sb at 0x1003
    cyc(1'b1, 32'h0000_1003, 32'h1234_56AB, 2'd2, 1'b0, 0, 1'b0);
    chk("sb_req", dm_req, 1);
    chk("sb_addr", dm_addr, 32'h0000_1000);
    chk("sb_be", dm_be, 4'b1000);
    chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
    idle(1'b1);
    chk("sb_ack_count", count, 0);
    chk("sb_ack_req", dm_req, 0);

    // sh good and misaligned, sw misaligned
    cyc(1'b1, 32'h0000_2002, 32'hFFFF_BEEF, 2'd1, 1'b0, 0, 1'b0);
    chk("sh_be", dm_be, 4'b1100);
    chk("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
    idle(1'b1);
    st_valid = 1; st_addr = 32'h2001; st_type = 2'd1; #1;
    chk("sh_mis", st_misalign, 1);
    cyc(1'b1, 32'h0000_2001, 32'h1, 2'd1, 1'b0, 0, 1'b0);
    chk("sh_mis_count", count, 0);
    cyc(1'b1, 32'h0000_2006, 32'h2, 2'd0, 1'b0, 0, 1'b0);
    chk("sw_mis_count", count, 0);

    // fill, third stalls, ack lets it in next cycle
    cyc(1'b1, 32'h0000_4000, 32'hA0, 2'd0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'h0000_4004, 32'hA1, 2'd0, 1'b0, 0, 1'b0);
    chk("full_count", count, 2);
    chk("full_ready", st_ready, 0);
    cyc(1'b1, 32'h0000_4008, 32'hA2, 2'd0, 1'b0, 0, 1'b0);
    chk("third_blocked", last_push, 0);
    cyc(1'b1, 32'h0000_4008, 32'hA2, 2'd0, 1'b0, 0, 1'b1);
    chk("full_pop_blocked", last_push, 0);
    cyc(1'b1, 32'h0000_4008, 32'hA2, 2'd0, 1'b0, 0, 1'b0);
    chk("third_accepted", last_push, 1);
    chk("order_head", dm_addr, 32'h0000_4004);
    idle(1'b1);
    chk("order_next", dm_addr, 32'h0000_4008);
    idle(1'b1);

    // full with continuous ack and valid
    accepted = 0; retired = 0;
    for (int i = 0; i < 60 && accepted < 20; i++)
      cyc(1'b1, 32'h0000_5000 + 32'(i * 4), 32'(i), 2'd0, 1'b0, 0, 1'b1);
    chk("stream_accepted", accepted, 20);
    while (q.size() != 0 && retired < 40) idle(1'b1);
    chk("stream_retired", retired, 20);

    // load hazard
    cyc(1'b1, 32'h0000_3004, 32'h55, 2'd0, 1'b0, 0, 1'b0);
    cyc(1'b0, 0, 0, 2'd3, 1'b1, 32'h0000_3006, 1'b0);
    chk("haz_same_word", ld_hazard, 1);
    cyc(1'b0, 0, 0, 2'd3, 1'b1, 32'h0000_3008, 1'b0);
    chk("haz_other_word", ld_hazard, 0);
    cyc(1'b0, 0, 0, 2'd3, 1'b1, 32'h0000_3006, 1'b1);
    ld_check = 1; ld_addr = 32'h3006; #1;
    chk("haz_after_ack", ld_hazard, 0);
    idle(1'b0);

    // async reset mid-cycle with two entries
    cyc(1'b1, 32'h0000_6000, 32'h1, 2'd0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'h0000_6004, 32'h2, 2'd0, 1'b0, 0, 1'b0);
    chk("pre_rst_count", count, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_req", dm_req, 0);
    chk("async_rst_count", count, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, la;
      a  = 32'h0000_7000 + 32'($urandom_range(0, 15));
      la = 32'h0000_7000 + 32'($urandom_range(0, 15));
      cyc(1'($urandom_range(0, 1)), a, $urandom, 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), la, 1'($urandom_range(0, 2) != 0));
    end
    while (q.size() != 0 && retired < 100000) idle(1'b1);
    chk("final_empty", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
Name: store_write_buffer

Overview:
- M-stage store path: the write-side counterpart of the W-stage load extraction.
- Takes sw/sh/sb requests and converts each to a word-aligned address, lane-replicated data and a 4-bit byte enable.
- Queues requests in a small in-order FIFO and drains them to data memory over a req/ack handshake.
- Flags misaligned stores and load-after-pending-store word hazards to the hazard unit.

Parameters:
- DEPTH, 2, number of buffered stores; power of two, 2..8.
- CNT_W, 2, width of the occupancy count; must equal clog2(DEPTH)+1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- st_valid  in  1  store request from M stage.
- st_addr  in  32  byte address (ALU result).
- st_data  in  32  unshifted rt value.
- st_type  in  2  store width: 00 word, 01 half, 10 byte, 11 none.
- st_ready  out  1  buffer can accept; equals !full.
- st_misalign  out  1  combinational address-error flag for the current request.
- ld_check  in  1  a load is in M this cycle.
- ld_addr  in  32  load byte address.
- ld_hazard  out  1  combinational; load word overlaps a pending store.
- dm_req  out  1  head entry valid toward data memory.
- dm_addr  out  32  word-aligned head address, bits [1:0] = 00.
- dm_wdata  out  32  lane-replicated head data.
- dm_be  out  4  head byte enable, bit i = byte lane i.
- dm_ack  in  1  memory accepted the head this cycle.
- count  out  CNT_W  number of valid entries.

Behaviour:
- Reset, asynchronous: pointers and count go to 0. Storage entries are cleared. Outputs go to dm_req=0, dm_addr=0, dm_wdata=0, dm_be=0, count=0, st_ready=1. Reset mid-drain discards all entries, with no partial retirement.
- Lane formatting is little-endian:
  - byte: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{data[15:0]}}.
  - word: be = 4'b1111, wdata = data.
- Misalignment:
  - st_misalign = st_valid & ((type==01 & addr[0]) | (type==00 & addr[1:0]!=0)).
  - It is independent of st_ready.
  - A misaligned or type==11 request is never enqueued.
- Push occurs when st_valid & st_ready & !st_misalign & st_type!=11. On the next edge the formatted entry is written at the tail and the tail and count are incremented.
- Head output:
  - dm_req = (count!=0).
  - dm_addr, dm_wdata and dm_be show the head entry while dm_req=1, and are forced to 0 when empty.
  - Earliest dm_req for a new store is the cycle after acceptance; there is no bypass path.
- Pop occurs when dm_req & dm_ack: the head advances on the next edge. dm_ack while dm_req=0 is ignored. dm_req stays asserted with stable outputs until acked.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, st_ready=0 even if a pop happens the same cycle.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never goes below 0.
- Ordering is strictly FIFO, with no merging or coalescing.
- ld_hazard = ld_check & OR over valid entries of (entry.addr[31:2] == ld_addr[31:2]):
  - An entry being popped this cycle still counts.
  - A store being pushed this cycle does not count; the pipeline's own M/W forwarding covers that case.
- count reflects the registered occupancy.

Test Plan:
- Reset with DEPTH=2, then sb with addr=0x0000_1003 and data=0x1234_56AB. Required: next cycle dm_req=1, dm_addr=0x0000_1000, dm_be=4'b1000, dm_wdata=0xABAB_ABAB. One-cycle dm_ack gives count=0 and dm_req=0.
- sh at 0x2002 with data 0xFFFF_BEEF. Required: dm_be=4'b1100, dm_wdata=0xBEEF_BEEF. sh at 0x2001 gives st_misalign=1, count stays 0. sw at 0x2006 gives st_misalign=1.
- With dm_ack held low, push three sw requests. Required: the first two are accepted with count=2 and st_ready=0, the third is not accepted. Then ack one while st_valid stays high: the third is accepted the cycle after st_ready returns, and the order on dm_addr is preserved.
- Buffer full with continuous dm_ack=1 and st_valid=1. Required: alternating accept/retire with no entry lost or duplicated over 20 stores.
- Pending sw at 0x3004 with ld_check=1: ld_addr=0x3006 gives ld_hazard=1, ld_addr=0x3008 gives ld_hazard=0. ld_hazard is still 1 in the same cycle the entry is acked and drops the next cycle.
- Assert reset asynchronously mid-cycle with count=2. Required: dm_req drops immediately, count=0, and after reset deasserts no stale entry appears.
